drum_trigger: RTL
=================

# drum_trigger

Upstream stage for the tom sample counter: turns a raw, bouncing active-low pushbutton into a clean single-cycle `go` strike pulse, and generates the one-cycle sample-rate `en` strobe that advances the counter. The strobe phase restarts on every strike, so sample 0 of each hit always lasts one full sample period. Outputs connect directly to the counter's `go` and `en` inputs.

## Interface
- `DEBOUNCE`, default 500000: cycles of stable level required to accept a press or release (10 ms at 50 MHz); legal range 1..2^20-1.
- `CLK_DIV`, default 1042: clock cycles per sample strobe (about 48 kHz at 50 MHz); legal range 2..65535.
- `clk`  in  1  system clock (50 MHz); every register updates on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `key_n`  in  1  raw pushbutton, active-low, asynchronous to `clk`.
- `run`  in  1  strobe gate; when low, the divider holds its value and `en` is 0.
- `go`  out  1  one-cycle pulse per accepted press (registered).
- `en`  out  1  one-cycle sample strobe, every `CLK_DIV` cycles (registered).
- `pressed`  out  1  debounced button level, 1 = held (registered).

## Operation
- Synchronizer: two flops on `key_n`, both reset to 1 (released). `p` = inverted output of the second flop.
- Debounce FSM with a 20-bit counter `dcnt`. States:
  - IDLE_UP: if `p`=1, go to WAIT_DOWN with `dcnt`=0.
  - WAIT_DOWN: if `p`=0, return to IDLE_UP. Otherwise, if `dcnt`==`DEBOUNCE`-1, go to HELD and set `go`=1 for one cycle. Otherwise increment `dcnt`.
  - HELD: `pressed`=1. If `p`=0, go to WAIT_UP with `dcnt`=0.
  - WAIT_UP: if `p`=1, return to HELD; no new `go`. Otherwise, if `dcnt`==`DEBOUNCE`-1, go to IDLE_UP and set `pressed`=0. Otherwise increment `dcnt`.
- `pressed` is 1 in HELD and WAIT_UP, and 0 in all other states. It is registered together with the state.
- A bounce shorter than `DEBOUNCE` cycles never produces `go` and never toggles `pressed`.
- Holding the button produces exactly one `go`. A new `go` requires a full release (back in IDLE_UP) followed by a full press.
- Divider: 16-bit `div`, updated on each edge in this priority order:
  1. If `go` is being set on this edge: `div` <= 0 and `en` <= 0.
  2. Else if `run`=0: `div` holds and `en` <= 0.
  3. Else if `div`==`CLK_DIV`-1: `div` <= 0 and `en` <= 1.
  4. Else: `div` <= `div`+1 and `en` <= 0.
- The phase restart in step 1 applies even when `run`=0.

## Timing
- Reset (asynchronous, `resetn`=0): `go`=0, `en`=0, `pressed`=0, state=IDLE_UP, `dcnt`=0, `div`=0, synchronizer flops=1. Outputs are 0 immediately, with no clock required.
- Press latency: call the first edge that samples `key_n`=0 edge 0.
  - Synchronizer output `p` rises after edge 1; WAIT_DOWN is entered at edge 2.
  - HELD is entered and `go` is set at edge `DEBOUNCE`+2.
  - `go` is high for exactly one cycle, and `pressed` rises on the same edge.
- Release latency: `pressed` falls at edge `DEBOUNCE`+2 after the first edge that samples `key_n`=1, assuming the level stays stable.
- Strobe timing with `run`=1:
  - First `en` after `go` rises at edge G+`CLK_DIV`, where G is the edge that set `go`.
  - Thereafter `en` has period `CLK_DIV` and is one cycle wide.
  - `en` and `go` are never high in the same cycle.
- Strike during strobe: if `go` is set on the edge where `div`==`CLK_DIV`-1, the strobe for that period is suppressed and the phase restarts.
- Reset mid-debounce or mid-hold: the block returns to IDLE_UP with no `go`. A key still held when reset releases is re-qualified from edge 0, then produces one `go`.
- Pausing: deasserting `run` freezes `div`. Reasserting `run` resumes from the frozen value, so the remaining part of the period is preserved.

## Test plan
- Reset: hold `resetn`=0 with `key_n` toggling → `go`, `en` and `pressed` stay 0. After release with `key_n`=1 → no `go` for 1000 cycles.
- Clean press (`DEBOUNCE`=4, `CLK_DIV`=5): hold `key_n` low from edge 0 → `go`=1 only in the cycle after edge 6, and `pressed`=1 from edge 6. Hold for 100 cycles → exactly one `go`.
- Bounce (`DEBOUNCE`=4): key low for 3 cycles, high for 1, repeated 10 times, then low steadily → zero `go` during the bounce, then exactly one `go` 6 edges after the final falling sample.
- Strobe (`CLK_DIV`=5, `run`=1): after `go` at edge G → `en` pulses at G+5, G+10, G+15, each exactly one cycle wide.
- Re-strike alignment: issue a second `go` mid-period (`div`=3) → no `en` at the old phase; next `en` at the new G+5. Drop `run` for 7 cycles → no `en`, and the period resumes after `run` returns.
- Reset mid-operation: assert `resetn`=0 at `dcnt`=2 in WAIT_DOWN → all outputs 0 immediately. Release `resetn` with the key still held → one `go` 6 edges later.

Source files
------------

// File: rtl/drum_trigger.sv
// drum_trigger: debounces an active-low key into a one-cycle go strike
// and derives a sample-rate en strobe whose phase restarts on every strike.
// Ports: clk, resetn (async, active-low), key_n (raw key), run (strobe gate)
//        go (strike pulse), en (sample strobe), pressed (debounced level).
module drum_trigger #(
  parameter int DEBOUNCE = 500000,
  parameter int CLK_DIV  = 1042
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  input  logic run,
  output logic go,
  output logic en,
  output logic pressed
);

  typedef enum logic [1:0] {
    IDLE_UP,
    WAIT_DOWN,
    HELD,
    WAIT_UP
  } state_t;

  localparam logic [19:0] DLAST = 20'(DEBOUNCE - 1);
  localparam logic [15:0] VLAST = 16'(CLK_DIV - 1);

  logic        s1, s2, p;
  state_t      state, state_n;
  logic [19:0] dcnt, dcnt_n;
  logic        go_n, pressed_n;
  logic [15:0] div;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  assign p = ~s2;

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    go_n    = 1'b0;
    case (state)
      IDLE_UP: begin
        if (p) begin
          state_n = WAIT_DOWN;
          dcnt_n  = '0;
        end
      end
      WAIT_DOWN: begin
        if (!p) begin
          state_n = IDLE_UP;
        end else if (dcnt == DLAST) begin
          state_n = HELD;
          go_n    = 1'b1;
        end else begin
          dcnt_n = dcnt + 20'd1;
        end
      end
      HELD: begin
        if (!p) begin
          state_n = WAIT_UP;
          dcnt_n  = '0;
        end
      end
      WAIT_UP: begin
        if (p) begin
          state_n = HELD;
        end else if (dcnt == DLAST) begin
          state_n = IDLE_UP;
        end else begin
          dcnt_n = dcnt + 20'd1;
        end
      end
      default: state_n = IDLE_UP;
    endcase
    pressed_n = (state_n == HELD) || (state_n == WAIT_UP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE_UP;
      dcnt    <= '0;
      go      <= 1'b0;
      pressed <= 1'b0;
    end else begin
      state   <= state_n;
      dcnt    <= dcnt_n;
      go      <= go_n;
      pressed <= pressed_n;
    end
  end

  // A strike restarts the phase even while paused, and wins over
  // a strobe that would otherwise fire on the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div <= '0;
      en  <= 1'b0;
    end else if (go_n) begin
      div <= '0;
      en  <= 1'b0;
    end else if (!run) begin
      en  <= 1'b0;
    end else if (div == VLAST) begin
      div <= '0;
      en  <= 1'b1;
    end else begin
      div <= div + 16'd1;
      en  <= 1'b0;
    end
  end

endmodule
